// File: rtl/mem_stage.sv
// mem_stage: RV32 memory stage, sitting directly after execute.
//
// Purpose:
//   Takes the ALU result, store data and control from execute. ALU ops retire
//   on the next edge. Loads and stores go through a req/ready/rvalid data-memory
//   handshake. Load data is lane-aligned and sign/zero-extended. The registered
//   writeback record (wb_*) doubles as the forwarding source for execute.
//   Upstream is stalled (ex_ready=0) while a memory transaction is outstanding.
//
// Handshake semantics:
//   ex:   a transfer happens on a rising edge where ex_valid && ex_ready.
//         Upstream holds its inputs while ex_ready is low.
//   dmem: a request transfers on a rising edge where dmem_req && dmem_ready.
//         dmem_rvalid is only honoured while waiting for load data (RESP).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   ex_valid / ex_ready   upstream handshake
//   ex_result             ALU result, also the load/store address
//   ex_store_data         forwarded rs2 for stores
//   ex_funct3             access width / signedness
//   ex_is_load/is_store   memory op type (both set means store)
//   ex_rd / ex_reg_we     destination register and write enable
//   dmem_*                data-memory request/response channel
//   wb_valid/rd/we/data   registered writeback record
//   misalign_trap         present only when MEM_MISALIGN_TRAP_EN is defined
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   When defined, misaligned half/word accesses trap in IDLE instead of
//   issuing a memory request.

module mem_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [XLEN-1:0] ex_result,
   input  logic [XLEN-1:0] ex_store_data,
   input  logic [2:0]      ex_funct3,
   input  logic            ex_is_load,
   input  logic            ex_is_store,
   input  logic [4:0]      ex_rd,
   input  logic            ex_reg_we,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic            dmem_ready,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic            wb_we,
   output logic [XLEN-1:0] wb_data
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic            misalign_trap
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   // state is a named signal so external checkers can bind to it directly.
   state_t            state;
   logic [XLEN-1:0]   lat_addr;
   logic [XLEN-1:0]   lat_sdata;
   logic [2:0]        lat_f3;
   logic              lat_store;
   logic [4:0]        lat_rd;
   logic              lat_we;

   logic [3:0]        st_be;
   logic [XLEN-1:0]   st_wdata;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [XLEN-1:0]   ld_data;
   logic              mis_access;

   // Memory-side outputs come only from latched state, never from ex_*.
   assign ex_ready   = (state == IDLE);
   assign dmem_req   = (state == REQ);
   assign dmem_we    = (state == REQ) && lat_store;
   assign dmem_addr  = {lat_addr[XLEN-1:2], 2'b00};
   assign dmem_be    = ((state == REQ) && lat_store) ? st_be : 4'b0000;
   assign dmem_wdata = st_wdata;

   // Store lane formation; unknown funct3 behaves as SW.
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = lat_sdata;
      case (lat_f3)
         3'b000: begin
            st_be    = 4'b0001 << lat_addr[1:0];
            st_wdata = {4{lat_sdata[7:0]}};
         end
         3'b001: begin
            st_be    = lat_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{lat_sdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Load extraction; unknown funct3 behaves as LW.
   always_comb begin
      ld_byte = dmem_rdata[7:0];
      case (lat_addr[1:0])
         2'd1:    ld_byte = dmem_rdata[15:8];
         2'd2:    ld_byte = dmem_rdata[23:16];
         2'd3:    ld_byte = dmem_rdata[31:24];
         default: ;
      endcase
      ld_half = lat_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (lat_f3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'h0, ld_byte};
         3'b101:  ld_data = {16'h0, ld_half};
         default: ld_data = dmem_rdata;
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   // Alignment check on the incoming op, using the same width decode as the
   // lane logic (unknown funct3 counts as a word access).
   always_comb begin
      mis_access = 1'b0;
      if (ex_is_store) begin
         case (ex_funct3)
            3'b000:  mis_access = 1'b0;
            3'b001:  mis_access = ex_result[0];
            default: mis_access = |ex_result[1:0];
         endcase
      end else if (ex_is_load) begin
         case (ex_funct3)
            3'b000, 3'b100: mis_access = 1'b0;
            3'b001, 3'b101: mis_access = ex_result[0];
            default:        mis_access = |ex_result[1:0];
         endcase
      end
   end
`else
   assign mis_access = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         lat_addr  <= '0;
         lat_sdata <= '0;
         lat_f3    <= 3'b000;
         lat_store <= 1'b0;
         lat_rd    <= 5'd0;
         lat_we    <= 1'b0;
         wb_valid  <= 1'b0;
         wb_rd     <= 5'd0;
         wb_we     <= 1'b0;
         wb_data   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_trap <= 1'b0;
`endif
      end else begin
         // Single-cycle pulses; wb_rd/wb_data hold their last value.
         wb_valid <= 1'b0;
         wb_we    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_trap <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (ex_valid) begin
                  if (ex_is_load || ex_is_store) begin
                     if (mis_access) begin
                        // Trap retires immediately with the faulting address.
                        wb_valid <= 1'b1;
                        wb_rd    <= ex_rd;
                        wb_data  <= ex_result;
`ifdef MEM_MISALIGN_TRAP_EN
                        misalign_trap <= 1'b1;
`endif
                     end else begin
                        lat_addr  <= ex_result;
                        lat_sdata <= ex_store_data;
                        lat_f3    <= ex_funct3;
                        lat_store <= ex_is_store;
                        lat_rd    <= ex_rd;
                        lat_we    <= ex_reg_we;
                        state     <= REQ;
                     end
                  end else begin
                     wb_valid <= 1'b1;
                     wb_rd    <= ex_rd;
                     wb_we    <= ex_reg_we && (ex_rd != 5'd0);
                     wb_data  <= ex_result;
                  end
               end
            end
            REQ: begin
               if (dmem_ready) begin
                  if (lat_store) begin
                     wb_valid <= 1'b1;
                     wb_rd    <= lat_rd;
                     state    <= IDLE;
                  end else begin
                     state <= RESP;
                  end
               end
            end
            RESP: begin
               if (dmem_rvalid) begin
                  wb_valid <= 1'b1;
                  wb_rd    <= lat_rd;
                  wb_we    <= lat_we && (lat_rd != 5'd0);
                  wb_data  <= ld_data;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
